// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit
//   Load/store sequencer in front of a 32x8 registered-read data memory.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  signal_memread,
   output logic                  signal_memwrite,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data_to_write,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   input  logic                  resp_ready,
   output logic [CNT_WIDTH-1:0]  load_count,
   output logic [CNT_WIDTH-1:0]  store_count
);

   localparam logic [CNT_WIDTH-1:0] c_CNT_INC = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t                r_state;
   logic                  r_req_ready;
   logic                  r_memread;
   logic                  r_memwrite;
   logic [ADDR_WIDTH-1:0] r_address;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_resp_valid;
   logic [DATA_WIDTH-1:0] r_resp_data;
   logic [CNT_WIDTH-1:0]  r_load_count;
   logic [CNT_WIDTH-1:0]  r_store_count;

   // Strobes are cleared by the async reset, so an in-flight store never reaches its commit edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_req_ready   <= 1'b1;
         r_memread     <= 1'b0;
         r_memwrite    <= 1'b0;
         r_address     <= '0;
         r_wdata       <= '0;
         r_resp_valid  <= 1'b0;
         r_resp_data   <= '0;
         r_load_count  <= '0;
         r_store_count <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_address   <= req_addr;
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  r_state     <= ST_ISSUE;
                  if (req_write) begin
                     r_memwrite    <= 1'b1;
                     r_store_count <= r_store_count + c_CNT_INC;
                  end else begin
                     r_memread    <= 1'b1;
                     r_load_count <= r_load_count + c_CNT_INC;
                  end
               end
            end
            ST_ISSUE: begin
               r_memread  <= 1'b0;
               r_memwrite <= 1'b0;
               if (r_memwrite) begin
                  r_req_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_resp_data  <= mem_data_out;
               r_resp_valid <= 1'b1;
               r_state      <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_memread    <= 1'b0;
               r_memwrite   <= 1'b0;
               r_resp_valid <= 1'b0;
               r_req_ready  <= 1'b1;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready       = r_req_ready;
   assign signal_memread  = r_memread;
   assign signal_memwrite = r_memwrite;
   assign address         = r_address;
   assign data_to_write   = r_wdata;
   assign resp_valid      = r_resp_valid;
   assign resp_data       = r_resp_data;
   assign load_count      = r_load_count;
   assign store_count     = r_store_count;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit
//   Directed + randomized bench with a cycle-count transaction model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [4:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       req_ready;
   logic       signal_memread;
   logic       signal_memwrite;
   logic [4:0] address;
   logic [7:0] data_to_write;
   logic [7:0] mem_data_out;
   logic       resp_valid;
   logic [7:0] resp_data;
   logic       resp_ready = 1'b1;
   logic [7:0] load_count;
   logic [7:0] store_count;

   mem_access_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready),
      .signal_memread(signal_memread), .signal_memwrite(signal_memwrite),
      .address(address), .data_to_write(data_to_write), .mem_data_out(mem_data_out),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
      .load_count(load_count), .store_count(store_count)
   );

   always #5 clock = ~clock;

   // Data memory with registered read port; not affected by the unit's reset.
   logic [7:0] mem [32];
   always @(posedge clock) begin
      if (signal_memwrite) mem[address] <= data_to_write;
      if (signal_memread)  mem_data_out <= mem[address];
   end

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a request occupies the unit for a number of cycles since its accept edge.
   bit         m_busy = 1'b0;
   bit         m_store = 1'b0;
   int         m_phase = 0;
   logic [4:0] m_addr = '0;
   logic [7:0] m_wdata = '0;
   logic [7:0] m_rdata = '0;
   bit         m_rknown = 1'b0;
   logic [7:0] m_loads = '0;
   logic [7:0] m_stores = '0;
   logic [7:0] ref_mem [32];
   bit         ref_known [32];

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_busy   <= 1'b0;
         m_phase  <= 0;
         m_addr   <= '0;
         m_wdata  <= '0;
         m_loads  <= '0;
         m_stores <= '0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy  <= 1'b1;
            m_phase <= 1;
            m_store <= req_write;
            m_addr  <= req_addr;
            m_wdata <= req_wdata;
            if (req_write) m_stores <= m_stores + 8'd1;
            else begin
               m_loads  <= m_loads + 8'd1;
               m_rdata  <= ref_mem[req_addr];
               m_rknown <= ref_known[req_addr];
            end
         end
      end else if (m_store) begin
         ref_mem[m_addr]   <= m_wdata;
         ref_known[m_addr] <= 1'b1;
         m_busy            <= 1'b0;
      end else if (m_phase < 3) begin
         m_phase <= m_phase + 1;
      end else if (resp_ready) begin
         m_busy <= 1'b0;
      end
   end

   int wr_cycles = 0;
   int both_cycles = 0;
   logic [4:0] last_wr_addr = '0;

   always @(negedge clock) begin
      if (signal_memwrite) begin
         wr_cycles++;
         last_wr_addr = address;
      end
      if (signal_memwrite && signal_memread) both_cycles++;
      if (chk_en) begin
         chk("req_ready", req_ready, !m_busy);
         chk("memwrite", signal_memwrite, m_busy && m_store);
         chk("memread", signal_memread, m_busy && !m_store && m_phase == 1);
         chk("resp_valid", resp_valid, m_busy && !m_store && m_phase == 3);
         chk("address", address, m_addr);
         chk("data_to_write", data_to_write, m_wdata);
         chk("load_count", load_count, m_loads);
         chk("store_count", store_count, m_stores);
         if (m_busy && !m_store && m_phase == 3 && m_rknown)
            chk("resp_data", resp_data, m_rdata);
      end
   end

   // Called at 1 time unit after a rising edge; returns likewise, just after the accept edge.
   task automatic do_req(input bit w, input logic [4:0] a, input logic [7:0] d);
      int n = 0;
      bit acc = 1'b0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      while (!acc && n < 50) begin
         @(negedge clock);
         acc = req_ready;
         @(posedge clock);
         #1;
         n++;
      end
      req_valid = 1'b0;
      if (!acc) begin
         n_checks++;
         n_errors++;
         $display("FAIL req_accept timeout addr=%0d", a);
      end
   endtask

   task automatic wait_resp(output logic [7:0] d);
      int n = 0;
      bit got = 1'b0;
      d = '0;
      while (!got && n < 50) begin
         @(negedge clock);
         if (resp_valid) begin
            got = 1'b1;
            d = resp_data;
         end
         @(posedge clock);
         #1;
         n++;
      end
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL resp_wait timeout");
      end
   endtask

   logic [7:0] dat [32];
   logic [7:0] rd;
   int w0;

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      chk_en = 1'b1;
      // reset state
      chk("rst_req_ready", req_ready, 1);
      chk("rst_memwrite", signal_memwrite, 0);
      chk("rst_memread", signal_memread, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_load_count", load_count, 0);
      chk("rst_store_count", store_count, 0);

      // store 5 <- A3, then load 5 with latency pinned
      w0 = wr_cycles;
      do_req(1'b1, 5'd5, 8'hA3);
      repeat (2) begin @(posedge clock); #1; end
      chk("st_wr_cycles", wr_cycles - w0, 1);
      chk("st_wr_addr", last_wr_addr, 5);
      do_req(1'b0, 5'd5, 8'h00);
      chk("ld_memread_e0", signal_memread, 1);
      chk("ld_rv_e0", resp_valid, 0);
      @(posedge clock); #1;
      chk("ld_memread_e1", signal_memread, 0);
      chk("ld_rv_e1", resp_valid, 0);
      @(posedge clock); #1;
      chk("ld_rv_e2", resp_valid, 1);
      chk("ld_data", resp_data, 8'hA3);
      @(posedge clock); #1;
      chk("ld_rv_e3", resp_valid, 0);
      chk("ld_ready_e3", req_ready, 1);

      // writeback stall with a pending store request
      resp_ready = 1'b0;
      do_req(1'b0, 5'd5, 8'h00);
      repeat (2) begin @(posedge clock); #1; end
      req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd9; req_wdata = 8'h11;
      repeat (4) begin
         @(negedge clock);
         chk("stall_rv", resp_valid, 1);
         chk("stall_data", resp_data, 8'hA3);
         chk("stall_ready", req_ready, 0);
         @(posedge clock); #1;
      end
      chk("stall_stores", store_count, 1);
      resp_ready = 1'b1;
      @(posedge clock); #1;
      chk("drain_ready", req_ready, 1);
      chk("drain_rv", resp_valid, 0);
      chk("drain_stores", store_count, 1);
      @(posedge clock); #1;
      chk("pending_accepted", store_count, 2);
      req_valid = 1'b0;

      // full sweep after a fresh reset
      reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         dat[i] = 8'($urandom);
         do_req(1'b1, 5'(i), dat[i]);
      end
      for (int i = 31; i >= 0; i--) begin
         do_req(1'b0, 5'(i), 8'h00);
         wait_resp(rd);
         chk("sweep_data", rd, dat[i]);
      end
      chk("sweep_loads", load_count, 32);
      chk("sweep_stores", store_count, 32);

      // store counter wrap
      for (int i = 0; i < 256; i++) begin
         do_req(1'b1, 5'(i), 8'(i ^ 8'h3C));
         if (i == 223) chk("wrap_zero", store_count, 0);
      end
      chk("wrap_stores", store_count, 32);
      chk("wrap_loads", load_count, 32);

      // reset while a store is in its issue cycle
      do_req(1'b1, 5'd7, 8'h9E);
      do_req(1'b1, 5'd7, 8'h55);
      chk("abort_wr_before", signal_memwrite, 1);
      reset = 1'b1;
      #1;
      chk("abort_wr_dropped", signal_memwrite, 0);
      @(posedge clock); #1 reset = 1'b0;
      chk("abort_loads", load_count, 0);
      chk("abort_stores", store_count, 0);
      do_req(1'b0, 5'd7, 8'h00);
      wait_resp(rd);
      chk("abort_old_data", rd, 8'h9E);

      // randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         req_valid  = ($urandom_range(0, 1) == 1);
         req_write  = ($urandom_range(0, 1) == 1);
         req_addr   = 5'($urandom);
         req_wdata  = 8'($urandom);
         resp_ready = ($urandom_range(0, 9) < 7);
         reset      = ($urandom_range(0, 299) == 0);
         @(posedge clock); #1;
      end
      reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      repeat (10) begin @(posedge clock); #1; end
      chk("never_both_strobes", both_cycles, 0);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
